// File: rtl/cpu_fetch_pkg.sv
// Shared types and helpers for the Thumb fetch front end.
// The FSM state enum and the test that detects 32-bit Thumb encodings.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [4:0] THUMB32_PREFIX_A = 5'b11101;
  localparam logic [4:0] THUMB32_PREFIX_B = 5'b11110;
  localparam logic [4:0] THUMB32_PREFIX_C = 5'b11111;

  function automatic logic is_thumb32(input logic [15:0] hw);
    return hw[15:11] inside {THUMB32_PREFIX_A, THUMB32_PREFIX_B, THUMB32_PREFIX_C};
  endfunction

endpackage

// File: rtl/halfword_fifo.sv
// Halfword queue: push 0/1/2 and pop 0/1/2 per cycle, flush, peek head and head+1.
// DEPTH must be a power of two so pointers wrap by natural overflow.
module halfword_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  logic [15:0]   push_data0,
  input  logic [15:0]   push_data1,
  input  logic [1:0]    pop_cnt,
  output logic [15:0]   head0,
  output logic [15:0]   head1,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_data0;
      if (push_cnt == 2'd2) mem[wr_ptr + PW'(1)] <= push_data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

endmodule

// File: rtl/thumb_fetch_unit.sv
// Buffered Thumb fetch: word reads into a halfword queue, 16/32-bit instruction assembly, redirect flush.
// Optional FETCH_STATS_EN adds saturating fire and stall counters (stat_inst, stat_stall).
module thumb_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 16,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic              inst_is32,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]       stat_inst,
  output logic [31:0]       stat_stall,
`endif
  output fetch_state_t      fetch_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state, state_next;
  logic              drop, drop_next;
  logic              skip_lo;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] pc_q;

  logic [15:0]   hw0, hw1;
  logic [CW-1:0] count;
  logic [1:0]    push_cnt, pop_cnt;
  logic [15:0]   push_data0;
  logic          head_is32, have_one, have_two, fire, accept, room;

  halfword_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push_cnt   (push_cnt),
    .push_data0 (push_data0),
    .push_data1 (mem_rdata[31:16]),
    .pop_cnt    (pop_cnt),
    .head0      (hw0),
    .head1      (hw1),
    .count      (count)
  );

  // Valid/ready: an instruction transfers on a cycle where inst_valid and inst_ready are both high;
  // inst_valid never depends on inst_ready, and a redirect cycle never transfers.
  assign head_is32  = is_thumb32(hw0);
  assign have_one   = (count != '0);
  assign have_two   = (count >= CW'(2));
  assign inst_is32  = have_one & head_is32;
  assign inst_valid = !redirect_valid & have_one & (!head_is32 | have_two);
  assign inst_data  = have_one ? {hw0, (inst_is32 & have_two) ? hw1 : 16'h0} : 32'h0;
  assign inst_pc    = pc_q;
  assign fire       = inst_valid & inst_ready;
  assign pop_cnt    = fire ? (inst_is32 ? 2'd2 : 2'd1) : 2'd0;

  // A read is only launched with two free slots reserved, so the response always fits.
  assign room       = (CW'(FIFO_DEPTH) - count) >= CW'(2);
  assign accept     = (state == WAIT) & mem_rvalid & !drop & !redirect_valid;
  assign push_cnt   = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
  assign push_data0 = skip_lo ? mem_rdata[31:16] : mem_rdata[15:0];

  assign mem_req     = (state == REQ);
  assign mem_addr    = fetch_addr;
  assign fetch_state = state;

  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      IDLE: if (!redirect_valid && room) state_next = REQ;
      REQ: begin
        if (mem_gnt) begin
          state_next = WAIT;
          drop_next  = redirect_valid;
        end else if (redirect_valid) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_next = IDLE;
          drop_next  = 1'b0;
        end else if (redirect_valid) begin
          drop_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drop       <= 1'b0;
      skip_lo    <= RESET_PC[1];
      fetch_addr <= {RESET_PC[ADDR_W-1:2], 2'b00};
      pc_q       <= {RESET_PC[ADDR_W-1:1], 1'b0};
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (redirect_valid) begin
        skip_lo    <= redirect_pc[1];
        fetch_addr <= {redirect_pc[ADDR_W-1:2], 2'b00};
        pc_q       <= {redirect_pc[ADDR_W-1:1], 1'b0};
      end else begin
        if (accept) begin
          skip_lo    <= 1'b0;
          fetch_addr <= fetch_addr + ADDR_W'(4);
        end
        if (fire) pc_q <= pc_q + (inst_is32 ? ADDR_W'(4) : ADDR_W'(2));
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic started;

  // Stalls are only counted once fetching has begun after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      stat_inst  <= '0;
      stat_stall <= '0;
    end else begin
      if (state != IDLE) started <= 1'b1;
      if (fire && stat_inst != '1) stat_inst <= stat_inst + 32'd1;
      if (!inst_valid && (started || state != IDLE) && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Directed bench for thumb_fetch_unit: memory responder, instruction-stream model, scoreboard, report.
module tb_thumb_fetch_unit;
  import cpu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_is32;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  fetch_state_t fetch_state;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_inst, stat_stall;
`endif

  always #5 clk = ~clk;

  thumb_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_is32      (inst_is32),
    .inst_pc        (inst_pc),
`ifdef FETCH_STATS_EN
    .stat_inst      (stat_inst),
    .stat_stall     (stat_stall),
`endif
    .fetch_state    (fetch_state)
  );

  logic [15:0] hw_mem [32768];
  logic [48:0] exp_q[$];          // {pc, is32, data}
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] log_pc[$];
  logic [31:0] log_data[$];
  logic        log_is32[$];
  logic [15:0] exp_fetch;
  int total = 0, bad = 0;
  int cyc = 0, fires = 0, grants = 0, lat = 1;
  int p3, p4, p5, p6, p7;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected decode stream from a start PC, straight from the memory image.
  function automatic void build_exp(input logic [15:0] start);
    logic [15:0] pc, pc2, h0, h1;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      pc2 = pc + 16'd2;
      h0 = hw_mem[pc[15:1]];
      h1 = hw_mem[pc2[15:1]];
      if (h0[15:11] >= 5'b11101) begin
        exp_q.push_back({pc, 1'b1, h0, h1});
        pc = pc + 16'd4;
      end else begin
        exp_q.push_back({pc, 1'b0, h0, 16'h0});
        pc = pc + 16'd2;
      end
    end
  endfunction

  // One cycle: drive memory, check outputs, advance to the next negedge.
  task automatic step();
    logic [15:0] a;
    logic [48:0] e;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      mem_rvalid = 1'b1;
      mem_rdata  = {hw_mem[{a[15:2], 1'b1}], hw_mem[{a[15:2], 1'b0}]};
    end
    mem_gnt = mem_req;
    #1;
    if (redirect_valid) check("valid_in_redirect", 64'(inst_valid), 64'd0);
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", 64'(inst_pc), 64'(e[48:33]));
        check("inst_is32", 64'(inst_is32), 64'(e[32]));
        check("inst_data", 64'(inst_data), 64'(e[31:0]));
      end
      log_pc.push_back(inst_pc);
      log_data.push_back(inst_data);
      log_is32.push_back(inst_is32);
      fires++;
    end
    if (mem_req && mem_gnt) begin
      check("one_outstanding", 64'(pend_addr.size()), 64'd0);
      check("mem_addr", 64'(mem_addr), 64'(exp_fetch));
      pend_addr.push_back(mem_addr);
      pend_due.push_back(cyc + lat);
      exp_fetch = exp_fetch + 16'd4;
      grants++;
    end
    if (redirect_valid) begin
      build_exp({redirect_pc[15:1], 1'b0});
      exp_fetch = {redirect_pc[15:2], 2'b00};
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_fires(input int n, input string name);
    int start = fires;
    int b = 0;
    while (fires - start < n && b < 200) begin
      step();
      b++;
    end
    check({"fires_", name}, 64'(fires - start), 64'(n));
  endtask

  task automatic redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int b;
    for (int i = 0; i < 32768; i++) hw_mem[i] = 16'h2000 | 16'(i[10:0]);
    hw_mem[0] = 16'h2001;  hw_mem[1] = 16'h2105;
    hw_mem[2] = 16'hF7FF;  hw_mem[3] = 16'hF000;
    hw_mem[9] = 16'h2A12;
    hw_mem[15'h83] = 16'hF000;  hw_mem[15'h84] = 16'hF800;
    hw_mem[15'h7FFF] = 16'hF000;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    build_exp(16'h0000);
    exp_fetch = 16'h0000;

    // Reset values, then the first request one cycle after release.
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_inst_is32", 64'(inst_is32), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 64'(mem_req), 64'd1);

    // Straight-line 16/32-bit stream from 0.
    inst_ready = 1'b1;
    run_fires(10, "linear");

    // 32-bit instruction straddling two words, entered at pc[1]=1.
    p3 = fires;
    redirect(16'h0106);
    run_fires(3, "straddle");

    // Back-pressure: queue fills, requests stop, nothing lost.
    inst_ready = 1'b0;
    redirect(16'h0040);
    b = grants;
    repeat (20) step();
    check("bp_grants_le2", 64'((grants - b) <= 2), 64'd1);
    check("bp_req_off", 64'(mem_req), 64'd0);
    check("bp_valid", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    p4 = fires;
    run_fires(8, "bp_drain");

    // Redirect while a read is outstanding: the late response is dropped.
    lat = 3;
    b = 0;
    while (pend_addr.size() == 0 && b < 50) begin step(); b++; end
    check("wait_reached", 64'(pend_addr.size()), 64'd1);
    p5 = fires;
    redirect(16'h0012);
    b = 0;
    while (!mem_req && b < 50) begin step(); b++; end
    check("redirect_fetch_addr", 64'(mem_addr), 64'h0010);
    run_fires(4, "after_drop");

    // Redirect coinciding with a would-be fire and an arriving response.
    lat = 1;
    inst_ready = 1'b0;
    redirect(16'h0300);
    b = 0;
    while (!(pend_addr.size() > 0 && pend_due[0] <= cyc && inst_valid) && b < 60) begin
      step();
      b++;
    end
    check("coincide_setup", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    p6 = fires;
    redirect(16'h0200);
    #1;
    check("valid_after_redirect", 64'(inst_valid), 64'd0);
    check("pc_after_redirect", 64'(inst_pc), 64'h0200);
    @(negedge clk);
    cyc++;
    run_fires(4, "after_coincide");

    // Fetch address wrap at the top of the address space.
    lat = 2;
    p7 = fires;
    redirect(16'hFFFC);
    run_fires(4, "wrap");

    // Literal pins on the model.
    check("lit0_pc", 64'(log_pc[0]), 64'h0000);
    check("lit0_data", 64'(log_data[0]), 64'h2001_0000);
    check("lit1_pc", 64'(log_pc[1]), 64'h0002);
    check("lit1_data", 64'(log_data[1]), 64'h2105_0000);
    check("lit2_pc", 64'(log_pc[2]), 64'h0004);
    check("lit2_data", 64'(log_data[2]), 64'hF7FF_F000);
    check("lit2_is32", 64'(log_is32[2]), 64'd1);
    check("lit3_pc", 64'(log_pc[3]), 64'h0008);
    check("lit3_data", 64'(log_data[3]), 64'h2004_0000);
    check("lit_straddle_pc", 64'(log_pc[p3]), 64'h0106);
    check("lit_straddle_data", 64'(log_data[p3]), 64'hF000_F800);
    check("lit_straddle_is32", 64'(log_is32[p3]), 64'd1);
    check("lit_bp_pc", 64'(log_pc[p4]), 64'h0040);
    check("lit_bp_data", 64'(log_data[p4]), 64'h2020_0000);
    check("lit_drop_pc", 64'(log_pc[p5]), 64'h0012);
    check("lit_drop_data", 64'(log_data[p5]), 64'h2A12_0000);
    check("lit_coincide_pc", 64'(log_pc[p6]), 64'h0200);
    check("lit_coincide_data", 64'(log_data[p6]), 64'h2100_0000);
    check("lit_wrap_pc", 64'(log_pc[p7 + 1]), 64'hFFFE);
    check("lit_wrap_data", 64'(log_data[p7 + 1]), 64'hF000_2001);
    check("lit_wrap_next_pc", 64'(log_pc[p7 + 2]), 64'h0002);
`ifdef FETCH_STATS_EN
    check("stat_inst", 64'(stat_inst), 64'(fires));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
